logic_capture_core: RTL and testbench
=====================================

Name: logic_capture_core

Overview:
Single-clock logic-analyzer capture engine. It samples a parallel input bus at a programmable divided rate and evaluates an 8-stage sequential trigger. Samples stream out on an AXI-Stream-style master port, both pre-trigger and for a programmed number of post-trigger samples. It feeds a downstream sample FIFO/DMA and reports arm/trigger/done status and the buffer position of the trigger sample.

Parameters:
size, 32, width of sampled input bus and of each trigger config word
max_div, 32, maximum clock division factor; ckdiv width = clog2(max_div)
saddr_w, 24, width of sample counters and buffer addresses

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
ckdiv  in  clog2(max_div)  sample every ckdiv+1 clk cycles
dinput  in  size  sampled input bus
arm  in  1  start capture (level, acted on when ready=1)
abort  in  1  cancel capture
trig_levelN_mask/type/level (N=1..8)  in  size each  trigger stage N config
post_trigger_count  in  saddr_w  samples emitted after trigger sample
buffer_size  in  saddr_w  downstream circular buffer length in samples
tdata  out  size  sample data
tvalid  out  1  sample valid
tready  in  1  downstream accept
srst  out  1  active-low reset to downstream FIFO
overrun  out  1  sticky: sample lost
armed  out  1  waiting for trigger
triggered  out  1  trigger seen, post-capture running
done  out  1  capture complete
ready  out  1  idle, arm accepted
trigger_pos  out  saddr_w  buffer index of trigger sample

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; tvalid=0, tdata=0, overrun=0, armed=0, triggered=0, done=0, ready=1, trigger_pos=0, srst=0, divider and counters 0.
- Sample strobe: divider counts 0..ckdiv, strobe on terminal count; ckdiv=0 -> every cycle, ckdiv=1 -> every 2nd cycle. Divider is held at 0 outside ARMED/POST.
- On a strobe, dinput is registered into the sample register. Edge detection compares it with the previous sample.
- Stage N match: for every bit with mask=1, type=0 (level) requires sample==level; type=1 (edge) requires rising (level=1) or falling (level=0) between previous and current sample. A stage with mask=0 is unused. The active sequence is stages 1..K, where K+1 is the first unused stage. If stage 1 is unused, the first sample after arming triggers.
- Stages are sequential: stage k+1 is evaluated only on samples strictly after the one matching stage k. Trigger fires when stage K matches.
- States:
  - IDLE (ready=1): arm=1 -> ARMED; srst=0 for that cycle; overrun, done and counters cleared.
  - ARMED (armed=1): every strobe emits a sample; sample counter increments modulo buffer_size (buffer_size=0 means 2^saddr_w). On trigger, trigger_pos := index of the trigger sample, then -> POST. If post_trigger_count=0, -> DONE instead.
  - POST (triggered=1): emits post_trigger_count further samples, then -> DONE after the last one is loaded.
  - DONE (done=1, ready=1): outputs hold until arm=1 -> ARMED (same actions as from IDLE).
  - Abort in ARMED/POST: -> IDLE next cycle; tvalid cleared; done stays 0. Abort has priority over trigger/arm in the same cycle. In IDLE/DONE abort is ignored.
- Output handshake:
  - Strobe sets tvalid=1 with the new sample on the next cycle.
  - tvalid&tready drops tvalid unless a new strobe arrives in the same cycle.
  - Strobe while tvalid=1 and tready=0: the new sample overwrites tdata and overrun is set (sticky until next arm).
- Latency: dinput -> tdata/tvalid is 1 clk after the strobe edge. Trigger status updates on the same edge the trigger sample is loaded.

Decomposition:
- Package logic_capture_pkg: state enum (IDLE, ARMED, POST, DONE); constants TRIG_TYPE_LEVEL=0, TRIG_TYPE_EDGE=1; NUM_STAGES=8.
- Sub-module trig_stage_match: combinational mask/type/level vs current/previous sample -> match and unused flags, instantiated 8 times.

Test Plan:
- Reset low 5 cycles -> ready=1, others 0, srst=0. Release -> srst=1.
- ckdiv=1, all masks 0, post_trigger_count=4, tready=1, arm pulse -> first sample triggers, trigger_pos=0; exactly 5 tvalid beats, one every 2 clk; done=1, ready=1.
- Stage1 mask=0x1 level type level=1; stage2 mask=0x2 rising edge; dinput sequence 0,1,1,3 -> trigger on the 4th sample; trigger_pos=3; triggered=1.
- buffer_size=128, trigger after 200 pre-trigger samples -> trigger_pos=200 mod 128=72.
- tready=0 during ARMED with ckdiv=0 -> overrun=1 on the 2nd sample; stays 1 until the next arm clears it.
- abort asserted in POST -> IDLE next cycle, tvalid=0, done=0, ready=1; re-arm works normally.

Source files
------------

// File: rtl/logic_capture_pkg.sv
// logic_capture_pkg: shared state encoding and trigger constants for the capture engine
package logic_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  localparam logic TRIG_TYPE_LEVEL = 1'b0;
  localparam logic TRIG_TYPE_EDGE = 1'b1;
  localparam int NUM_STAGES = 8;
endpackage

// File: rtl/trig_stage_match.sv
// trig_stage_match: one trigger stage, compares current/previous sample against mask/type/level
module trig_stage_match
  import logic_capture_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [size-1:0] mask,
  input  logic [size-1:0] typ,
  input  logic [size-1:0] level,
  input  logic [size-1:0] cur,
  input  logic [size-1:0] prev,
  output logic            match,
  output logic            unused
);
  logic [size-1:0] edge_sel, edge_ok, lvl_ok;
  assign edge_sel = TRIG_TYPE_EDGE ? typ : ~typ;
  assign edge_ok = (level & ~prev & cur) | (~level & prev & ~cur);
  assign lvl_ok = ~(cur ^ level);
  assign match = &(~mask | (edge_sel & edge_ok) | (~edge_sel & lvl_ok));
  assign unused = ~|mask;
endmodule

// File: rtl/logic_capture_core.sv
// logic_capture_core: divided-rate sampler with 8-stage sequential trigger and stream output
module logic_capture_core
  import logic_capture_pkg::*;
#(
  parameter int size = 32,
  parameter int max_div = 32,
  parameter int saddr_w = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(max_div)-1:0] ckdiv,
  input  logic [size-1:0]            dinput,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [size-1:0]            trig_level1_mask,
  input  logic [size-1:0]            trig_level1_type,
  input  logic [size-1:0]            trig_level1_level,
  input  logic [size-1:0]            trig_level2_mask,
  input  logic [size-1:0]            trig_level2_type,
  input  logic [size-1:0]            trig_level2_level,
  input  logic [size-1:0]            trig_level3_mask,
  input  logic [size-1:0]            trig_level3_type,
  input  logic [size-1:0]            trig_level3_level,
  input  logic [size-1:0]            trig_level4_mask,
  input  logic [size-1:0]            trig_level4_type,
  input  logic [size-1:0]            trig_level4_level,
  input  logic [size-1:0]            trig_level5_mask,
  input  logic [size-1:0]            trig_level5_type,
  input  logic [size-1:0]            trig_level5_level,
  input  logic [size-1:0]            trig_level6_mask,
  input  logic [size-1:0]            trig_level6_type,
  input  logic [size-1:0]            trig_level6_level,
  input  logic [size-1:0]            trig_level7_mask,
  input  logic [size-1:0]            trig_level7_type,
  input  logic [size-1:0]            trig_level7_level,
  input  logic [size-1:0]            trig_level8_mask,
  input  logic [size-1:0]            trig_level8_type,
  input  logic [size-1:0]            trig_level8_level,
  input  logic [saddr_w-1:0]         post_trigger_count,
  input  logic [saddr_w-1:0]         buffer_size,
  output logic [size-1:0]            tdata,
  output logic                       tvalid,
  input  logic                       tready,
  output logic                       srst,
  output logic                       overrun,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic                       ready,
  output logic [saddr_w-1:0]         trigger_pos
);
  localparam int DW = $clog2(max_div);
  localparam int SW = $clog2(NUM_STAGES);
  state_t state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [saddr_w-1:0] scnt, pcnt, scnt_nxt, pcnt_nxt;
  logic [SW-1:0] stg;
  logic [NUM_STAGES-1:0] match, unused;
  logic [NUM_STAGES:0] unused_x;
  logic [size-1:0] t_mask [NUM_STAGES];
  logic [size-1:0] t_type [NUM_STAGES];
  logic [size-1:0] t_level [NUM_STAGES];
  logic active, start, abort_act, strobe, stg_last, stg_adv, fire, post_end;
  assign t_mask = '{trig_level1_mask, trig_level2_mask, trig_level3_mask, trig_level4_mask,
                    trig_level5_mask, trig_level6_mask, trig_level7_mask, trig_level8_mask};
  assign t_type = '{trig_level1_type, trig_level2_type, trig_level3_type, trig_level4_type,
                    trig_level5_type, trig_level6_type, trig_level7_type, trig_level8_type};
  assign t_level = '{trig_level1_level, trig_level2_level, trig_level3_level, trig_level4_level,
                     trig_level5_level, trig_level6_level, trig_level7_level, trig_level8_level};
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    trig_stage_match #(.size(size)) u_match (
      .mask(t_mask[i]),
      .typ(t_type[i]),
      .level(t_level[i]),
      .cur(dinput),
      .prev(tdata),
      .match(match[i]),
      .unused(unused[i])
    );
  end
  assign active = state == ARMED || state == POST;
  assign start = (state == IDLE || state == DONE) && arm;
  assign abort_act = active && abort;
  assign strobe = active && !abort && div_cnt == ckdiv;
  assign unused_x = {1'b1, unused};
  assign stg_last = unused_x[{1'b0, stg} + 1'b1];
  assign fire = strobe && state == ARMED && (unused[stg] || (match[stg] && stg_last));
  assign stg_adv = strobe && state == ARMED && match[stg] && !unused[stg] && !stg_last;
  assign scnt_nxt = scnt + 1'b1;
  assign pcnt_nxt = pcnt + 1'b1;
  assign post_end = strobe && state == POST && pcnt_nxt == post_trigger_count;
  // state register
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nxt;
  // next state: arm, abort, trigger and end of post-capture
  always_comb begin
    state_nxt = start ? ARMED
              : abort_act ? IDLE
              : fire ? (post_trigger_count == '0 ? DONE : POST)
              : post_end ? DONE
              : state;
  end
  // status outputs decoded from state
  always_comb begin
    ready = state == IDLE || state == DONE;
    armed = state == ARMED;
    triggered = state == POST;
    done = state == DONE;
  end
  // divider, sample/stream register, counters and trigger position
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      tdata <= '0;
      tvalid <= 1'b0;
      overrun <= 1'b0;
      srst <= 1'b0;
      scnt <= '0;
      pcnt <= '0;
      stg <= '0;
      trigger_pos <= '0;
    end else begin
      div_cnt <= (active && !strobe && !abort) ? div_cnt + 1'b1 : '0;
      srst <= !start;
      if (start) begin
        overrun <= 1'b0;
        scnt <= '0;
        pcnt <= '0;
        stg <= '0;
      end
      if (abort_act) tvalid <= 1'b0;
      else if (strobe) begin
        tvalid <= 1'b1;
        tdata <= dinput;
        if (tvalid && !tready) overrun <= 1'b1;
        scnt <= scnt_nxt == buffer_size ? '0 : scnt_nxt;
        if (fire) trigger_pos <= scnt;
        if (stg_adv) stg <= stg + 1'b1;
        if (state == POST) pcnt <= pcnt_nxt;
      end else if (tready) tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_logic_capture_core.sv
// tb_logic_capture_core: scenario tasks with a stream scoreboard for logic_capture_core
module tb_logic_capture_core;
  logic clk = 1'b0, reset = 1'b0, arm = 1'b0, abort = 1'b0, tready = 1'b0;
  logic [4:0] ckdiv = '0;
  logic [31:0] dinput = '0;
  logic [31:0] tm [8];
  logic [31:0] tt [8];
  logic [31:0] tl [8];
  logic [23:0] post_trigger_count = '0, buffer_size = '0;
  logic [31:0] tdata;
  logic tvalid, srst, overrun, armed, triggered, done, ready;
  logic [23:0] trigger_pos;
  int vectors = 0, miscompares = 0, beats = 0;
  bit sb_en = 1'b0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  logic_capture_core dut (
    .clk(clk), .reset(reset), .ckdiv(ckdiv), .dinput(dinput), .arm(arm), .abort(abort),
    .trig_level1_mask(tm[0]), .trig_level1_type(tt[0]), .trig_level1_level(tl[0]),
    .trig_level2_mask(tm[1]), .trig_level2_type(tt[1]), .trig_level2_level(tl[1]),
    .trig_level3_mask(tm[2]), .trig_level3_type(tt[2]), .trig_level3_level(tl[2]),
    .trig_level4_mask(tm[3]), .trig_level4_type(tt[3]), .trig_level4_level(tl[3]),
    .trig_level5_mask(tm[4]), .trig_level5_type(tt[4]), .trig_level5_level(tl[4]),
    .trig_level6_mask(tm[5]), .trig_level6_type(tt[5]), .trig_level6_level(tl[5]),
    .trig_level7_mask(tm[6]), .trig_level7_type(tt[6]), .trig_level7_level(tl[6]),
    .trig_level8_mask(tm[7]), .trig_level8_type(tt[7]), .trig_level8_level(tl[7]),
    .post_trigger_count(post_trigger_count), .buffer_size(buffer_size),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .srst(srst), .overrun(overrun),
    .armed(armed), .triggered(triggered), .done(done), .ready(ready), .trigger_pos(trigger_pos)
  );

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (sb_en && tvalid && tready) begin
      beats++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra_beat: got tdata=%h, required no beat", tdata);
      end else begin
        e = exp_q.pop_front();
        if (tdata !== e) begin
          miscompares++;
          $display("FAIL sb_tdata: got %h, required %h", tdata, e);
        end
      end
    end
  end

  task automatic clear_stages;
    for (int i = 0; i < 8; i++) begin
      tm[i] = '0;
      tt[i] = '0;
      tl[i] = '0;
    end
  endtask

  task automatic arm_pulse;
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    dinput = v;
    if (sb_en) exp_q.push_back(v);
    repeat (int'(ckdiv) + 1) @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input int n);
    repeat (3) @(negedge clk);
    vectors++;
    if (beats !== n || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL beat_count: got %0d beats (%0d pending), required %0d", beats, exp_q.size(), n);
    end
    sb_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ready, armed, triggered, done, tvalid, overrun, srst} !== 7'b1000000 || tdata !== '0 || trigger_pos !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy/arm/trg/done/tv/ovr/srst=%b tdata=%h pos=%0d, required 1000000 0 0",
               {ready, armed, triggered, done, tvalid, overrun, srst}, tdata, trigger_pos);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (srst !== 1'b1) begin
      miscompares++;
      $display("FAIL srst_release: got %b, required 1", srst);
    end
  endtask

  task automatic test_free_trigger;
    clear_stages();
    ckdiv = 5'd1; post_trigger_count = 24'd4; buffer_size = '0; tready = 1'b1;
    beats = 0; sb_en = 1'b1;
    arm_pulse();
    @(negedge clk);
    vectors++;
    if (srst !== 1'b0 || armed !== 1'b1) begin
      miscompares++;
      $display("FAIL arm_entry: got srst=%b armed=%b, required srst=0 armed=1", srst, armed);
    end
    for (int s = 0; s < 5; s++) send(32'hA000 + s);
    @(negedge clk);
    vectors++;
    if ({done, ready, triggered} !== 3'b110 || trigger_pos !== 24'd0) begin
      miscompares++;
      $display("FAIL free_done: got done/rdy/trg=%b pos=%0d, required 110 pos=0", {done, ready, triggered}, trigger_pos);
    end
    drain_check(5);
  endtask

  task automatic test_seq_trigger;
    clear_stages();
    tm[0] = 32'h1; tt[0] = 32'h0; tl[0] = 32'h1;
    tm[1] = 32'h2; tt[1] = 32'h2; tl[1] = 32'h2;
    ckdiv = '0; post_trigger_count = 24'd2; buffer_size = '0; tready = 1'b1;
    beats = 0; sb_en = 1'b1;
    arm_pulse();
    send(32'h0); send(32'h1); send(32'h1);
    @(negedge clk);
    vectors++;
    if (armed !== 1'b1 || triggered !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_no_early: got armed=%b triggered=%b, required 1 0", armed, triggered);
    end
    send(32'h3);
    @(negedge clk);
    vectors++;
    if (triggered !== 1'b1 || trigger_pos !== 24'd3) begin
      miscompares++;
      $display("FAIL seq_trigger: got triggered=%b pos=%0d, required 1 3", triggered, trigger_pos);
    end
    send(32'h5); send(32'h6);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_done: got %b, required 1", done);
    end
    drain_check(6);
  endtask

  task automatic test_buffer_wrap;
    clear_stages();
    tm[0] = 32'hFFFF_FFFF; tl[0] = 32'd200;
    ckdiv = '0; post_trigger_count = '0; buffer_size = 24'd128; tready = 1'b1;
    beats = 0; sb_en = 1'b1;
    arm_pulse();
    for (int s = 0; s <= 200; s++) send(s);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || triggered !== 1'b0 || trigger_pos !== 24'd72 || tdata !== 32'd200) begin
      miscompares++;
      $display("FAIL wrap_pos: got done=%b trg=%b pos=%0d tdata=%0d, required 1 0 72 200", done, triggered, trigger_pos, tdata);
    end
    drain_check(201);
    buffer_size = '0;
  endtask

  task automatic test_overrun;
    clear_stages();
    tm[0] = 32'hFFFF_FFFF; tl[0] = 32'hDEAD_BEEF;
    ckdiv = '0; post_trigger_count = '0; tready = 1'b0; sb_en = 1'b0;
    arm_pulse();
    send(32'h1);
    @(negedge clk);
    vectors++;
    if (tvalid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_first: got tvalid=%b overrun=%b, required 1 0", tvalid, overrun);
    end
    send(32'h2);
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b1 || tdata !== 32'h2) begin
      miscompares++;
      $display("FAIL ovr_second: got overrun=%b tdata=%h, required 1 00000002", overrun, tdata);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ready, tvalid, done, overrun} !== 4'b1001) begin
      miscompares++;
      $display("FAIL ovr_sticky: got rdy/tv/done/ovr=%b, required 1001", {ready, tvalid, done, overrun});
    end
    arm_pulse();
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b0 || armed !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_clear: got overrun=%b armed=%b, required 0 1", overrun, armed);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_abort_post;
    clear_stages();
    ckdiv = '0; post_trigger_count = 24'd10; tready = 1'b1; sb_en = 1'b0;
    arm_pulse();
    send(32'h11); send(32'h22); send(32'h33);
    @(negedge clk);
    vectors++;
    if (triggered !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: got triggered=%b, required 1", triggered);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ready, armed, triggered, done, tvalid} !== 5'b10000) begin
      miscompares++;
      $display("FAIL abort_idle: got rdy/arm/trg/done/tv=%b, required 10000", {ready, armed, triggered, done, tvalid});
    end
    post_trigger_count = 24'd1; beats = 0; sb_en = 1'b1;
    arm_pulse();
    send(32'h55); send(32'h66);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || trigger_pos !== 24'd0) begin
      miscompares++;
      $display("FAIL rearm_done: got done=%b pos=%0d, required 1 0", done, trigger_pos);
    end
    drain_check(2);
  endtask

  initial begin
    clear_stages();
    test_reset();
    test_free_trigger();
    test_seq_trigger();
    test_buffer_wrap();
    test_overrun();
    test_abort_post();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
